// File: rtl/rv_pkg.sv
// Shared types and constants for the integer register-file writeback scheduler.
package rv_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned RA_W = 5;
    localparam int unsigned NREG = 32'(1) << RA_W;

    typedef logic [RA_W-1:0] reg_idx_t;
    typedef logic [XLEN-1:0] xdata_t;

    typedef struct packed {
        logic     valid;
        reg_idx_t rd;
        xdata_t   data;
    } wb_req_t;

    typedef enum logic [1:0] {
        WB_NONE,
        WB_ALU,
        WB_LDBUF,
        WB_LDBYP
    } wb_src_e;

endpackage

// File: rtl/rv_regs_scoreboard.sv
// Per-register busy scoreboard: tracks destinations of in-flight instructions
// and flags RAW/WAW hazards for the instruction presented at issue.
module rv_regs_scoreboard
    import rv_pkg::*;
(
    input  logic     i_clk,
    input  logic     i_reset_n,
    input  logic     i_set_en,
    input  reg_idx_t i_set_idx,
    input  logic     i_clr_en,
    input  reg_idx_t i_clr_idx,
    input  reg_idx_t i_rs1,
    input  reg_idx_t i_rs2,
    input  logic     i_use_rs1,
    input  logic     i_use_rs2,
    input  reg_idx_t i_rd,
    output logic     o_hazard_c,
    output logic     o_clr_busy_c
);

    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_nxt;

    // Set takes priority over clear; x0 can never become busy.
    always_comb begin
        w_busy_nxt = r_busy;
        if (i_clr_en) begin
            w_busy_nxt[i_clr_idx] = 1'b0;
        end
        if (i_set_en) begin
            w_busy_nxt[i_set_idx] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign o_hazard_c   = (i_use_rs1 & r_busy[i_rs1])
                        | (i_use_rs2 & r_busy[i_rs2])
                        | r_busy[i_rd];
    assign o_clr_busy_c = r_busy[i_clr_idx];

endmodule

// File: rtl/rv_regs_wb_sched.sv
// Issue-hazard and writeback scheduler for the integer register file:
// arbitrates ALU and load writebacks onto one write port with a one-entry load buffer.
module rv_regs_wb_sched
    import rv_pkg::*;
(
    input  logic     i_clk,
    input  logic     i_reset_n,
    input  logic     i_issue_valid,
    input  reg_idx_t i_issue_rs1,
    input  reg_idx_t i_issue_rs2,
    input  logic     i_issue_use_rs1,
    input  logic     i_issue_use_rs2,
    input  reg_idx_t i_issue_rd,
    output logic     o_issue_stall,
    input  logic     i_alu_valid,
    input  reg_idx_t i_alu_rd,
    input  xdata_t   i_alu_data,
    input  logic     i_ld_valid,
    output logic     o_ld_ready,
    input  reg_idx_t i_ld_rd,
    input  xdata_t   i_ld_data,
    output logic     o_rf_write,
    output reg_idx_t o_rf_rd,
    output xdata_t   o_rf_data,
    output logic     o_wb_err
);

    wb_req_t r_ld_buf;
    logic    r_wb_err;

    wb_src_e w_src;
    wb_req_t w_wb;
    logic    w_alu_write;
    logic    w_ld_capture;
    logic    w_rf_write;
    logic    w_issue_accept;
    logic    w_hazard_c;
    logic    w_clr_busy_c;

    // Write-port arbitration: ALU, then buffered load, then load bypass.
    always_comb begin
        w_src        = WB_NONE;
        w_wb         = '0;
        w_alu_write  = i_alu_valid & (i_alu_rd != '0);
        w_ld_capture = 1'b0;
        if (w_alu_write) begin
            w_src        = WB_ALU;
            w_ld_capture = i_ld_valid & ~r_ld_buf.valid;
        end else if (r_ld_buf.valid) begin
            w_src = WB_LDBUF;
        end else if (i_ld_valid) begin
            w_src = WB_LDBYP;
        end
        case (w_src)
            WB_ALU:   w_wb = '{valid: 1'b1, rd: i_alu_rd, data: i_alu_data};
            WB_LDBUF: w_wb = r_ld_buf;
            WB_LDBYP: w_wb = '{valid: 1'b1, rd: i_ld_rd, data: i_ld_data};
            default:  w_wb = '0;
        endcase
    end

    // A writeback to x0 completes its handshake but never reaches the port.
    assign w_rf_write     = i_reset_n & w_wb.valid & (w_wb.rd != '0);
    assign o_issue_stall  = ~i_reset_n | r_ld_buf.valid | w_hazard_c;
    assign w_issue_accept = i_issue_valid & ~o_issue_stall;

    assign o_ld_ready = i_reset_n & ~r_ld_buf.valid;
    assign o_rf_write = w_rf_write;
    assign o_rf_rd    = w_wb.rd;
    assign o_rf_data  = w_wb.data;
    assign o_wb_err   = r_wb_err;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_ld_buf <= '0;
            r_wb_err <= 1'b0;
        end else begin
            if (w_ld_capture) begin
                r_ld_buf <= '{valid: 1'b1, rd: i_ld_rd, data: i_ld_data};
            end else if (w_src == WB_LDBUF) begin
                r_ld_buf.valid <= 1'b0;
            end
            r_wb_err <= r_wb_err | (w_rf_write & ~w_clr_busy_c);
        end
    end

    rv_regs_scoreboard u_scoreboard (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_set_en     (w_issue_accept & (i_issue_rd != '0)),
        .i_set_idx    (i_issue_rd),
        .i_clr_en     (w_rf_write),
        .i_clr_idx    (w_wb.rd),
        .i_rs1        (i_issue_rs1),
        .i_rs2        (i_issue_rs2),
        .i_use_rs1    (i_issue_use_rs1),
        .i_use_rs2    (i_issue_use_rs2),
        .i_rd         (i_issue_rd),
        .o_hazard_c   (w_hazard_c),
        .o_clr_busy_c (w_clr_busy_c)
    );

endmodule

// File: tb/tb_rv_regs_wb_sched.sv
// Self-checking bench for rv_regs_wb_sched: directed scenarios plus randomized
// traffic against a queue-based behavioural model.
module tb_rv_regs_wb_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue_valid, use_rs1, use_rs2;
    logic [4:0]  rs1, rs2, issue_rd;
    logic        issue_stall;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_valid, ld_ready;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        rf_write, wb_err;
    logic [4:0]  rf_rd;
    logic [31:0] rf_data;

    always #5 clk = ~clk;

    rv_regs_wb_sched dut (
        .i_clk           (clk),
        .i_reset_n       (rst_n),
        .i_issue_valid   (issue_valid),
        .i_issue_rs1     (rs1),
        .i_issue_rs2     (rs2),
        .i_issue_use_rs1 (use_rs1),
        .i_issue_use_rs2 (use_rs2),
        .i_issue_rd      (issue_rd),
        .o_issue_stall   (issue_stall),
        .i_alu_valid     (alu_valid),
        .i_alu_rd        (alu_rd),
        .i_alu_data      (alu_data),
        .i_ld_valid      (ld_valid),
        .o_ld_ready      (ld_ready),
        .i_ld_rd         (ld_rd),
        .i_ld_data       (ld_data),
        .o_rf_write      (rf_write),
        .o_rf_rd         (rf_rd),
        .o_rf_data       (rf_data),
        .o_wb_err        (wb_err)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    bit   m_busy [32];
    ent_t m_buf [$];
    bit   m_err;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   g_iss_acc, g_ld_acc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic idle();
        issue_valid = 0; use_rs1 = 0; use_rs2 = 0; rs1 = 0; rs2 = 0; issue_rd = 0;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        ld_valid = 0; ld_rd = 0; ld_data = 0;
    endtask

    // One clock: compare outputs with the model, then advance the model at the edge.
    task automatic cycle();
        bit aw, ew, er, es;
        logic [4:0]  erd;
        logic [31:0] ed;
        ew = 0; er = 0; es = 1; erd = 0; ed = 0; aw = 0;
        #1;
        if (rst_n) begin
            aw = alu_valid && (alu_rd != 0);
            er = (m_buf.size() == 0);
            es = (m_buf.size() != 0) || (use_rs1 && m_busy[rs1]) ||
                 (use_rs2 && m_busy[rs2]) || m_busy[issue_rd];
            if (aw) begin
                ew = 1; erd = alu_rd; ed = alu_data;
            end else if (m_buf.size() != 0) begin
                erd = m_buf[0].rd; ed = m_buf[0].data; ew = (erd != 0);
            end else if (ld_valid) begin
                erd = ld_rd; ed = ld_data; ew = (erd != 0);
            end
        end
        chk("stall", 64'(issue_stall), 64'(es));
        chk("rf_write", 64'(rf_write), 64'(ew));
        if (ew) begin
            chk("rf_rd", 64'(rf_rd), 64'(erd));
            chk("rf_data", 64'(rf_data), 64'(ed));
        end
        chk("ld_ready", 64'(ld_ready), 64'(er));
        chk("wb_err", 64'(wb_err), 64'(m_err));
        g_iss_acc = rst_n && issue_valid && !es;
        g_ld_acc  = rst_n && ld_valid && er;
        @(posedge clk);
        if (!rst_n) begin
            foreach (m_busy[i]) m_busy[i] = 0;
            m_buf.delete();
            m_err = 0;
        end else begin
            if (ew) begin
                if (!m_busy[erd]) m_err = 1;
                m_busy[erd] = 0;
            end
            if (g_iss_acc && issue_rd != 0) m_busy[issue_rd] = 1;
            if (!aw && m_buf.size() != 0) void'(m_buf.pop_front());
            else if (aw && ld_valid && m_buf.size() == 0) m_buf.push_back('{ld_rd, ld_data});
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        cycle();
        cycle();
        rst_n = 1;
    endtask

    task automatic issue_one(input logic [4:0] rd);
        idle();
        issue_valid = 1; issue_rd = rd;
        cycle();
    endtask

    logic [4:0] pool [$];
    bit         ld_active;
    int         idx;

    initial begin
        m_err = 0;
        foreach (m_busy[i]) m_busy[i] = 0;
        idle();
        rst_n = 0;
        @(negedge clk);
        #1 chk("reset_stall", 64'(issue_stall), 64'(1));
        chk("reset_write", 64'(rf_write), 64'(0));
        do_reset();
        #1 chk("post_reset_stall", 64'(issue_stall), 64'(0));

        // RAW on x5 resolved by an ALU writeback
        issue_one(5'd5);
        idle(); use_rs1 = 1; rs1 = 5'd5; issue_valid = 1;
        #1 chk("raw_stall", 64'(issue_stall), 64'(1));
        cycle();
        alu_valid = 1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        #1 chk("alu_write", 64'(rf_write), 64'(1));
        chk("alu_rd", 64'(rf_rd), 64'(5));
        chk("alu_data", 64'(rf_data), 64'hDEADBEEF);
        chk("raw_stall_wcyc", 64'(issue_stall), 64'(1));
        cycle();
        alu_valid = 0;
        #1 chk("raw_release", 64'(issue_stall), 64'(0));
        cycle();

        // ALU and load collide: load goes through the buffer
        issue_one(5'd3);
        issue_one(5'd7);
        idle();
        alu_valid = 1; alu_rd = 5'd3; alu_data = 32'h0A0A0A0A;
        ld_valid = 1; ld_rd = 5'd7; ld_data = 32'h77665544;
        #1 chk("coll_rd", 64'(rf_rd), 64'(3));
        chk("coll_ready", 64'(ld_ready), 64'(1));
        cycle();
        idle(); issue_valid = 1;
        #1 chk("buf_rd", 64'(rf_rd), 64'(7));
        chk("buf_data", 64'(rf_data), 64'h77665544);
        chk("buf_stall", 64'(issue_stall), 64'(1));
        chk("buf_ready", 64'(ld_ready), 64'(0));
        cycle();
        idle();
        #1 chk("buf_drained", 64'(issue_stall), 64'(0));
        cycle();

        // Load bypass
        issue_one(5'd9);
        idle(); ld_valid = 1; ld_rd = 5'd9; ld_data = 32'h99990000;
        #1 chk("byp_write", 64'(rf_write), 64'(1));
        chk("byp_rd", 64'(rf_rd), 64'(9));
        chk("byp_ready", 64'(ld_ready), 64'(1));
        cycle();
        idle(); use_rs1 = 1; rs1 = 5'd9; issue_valid = 1;
        #1 chk("byp_release", 64'(issue_stall), 64'(0));
        cycle();

        // x0 destination
        issue_one(5'd0);
        idle(); alu_valid = 1; alu_data = 32'h1234;
        #1 chk("x0_alu_write", 64'(rf_write), 64'(0));
        cycle();
        idle(); ld_valid = 1; ld_data = 32'h1234; issue_valid = 1;
        #1 chk("x0_ld_write", 64'(rf_write), 64'(0));
        chk("x0_ld_ready", 64'(ld_ready), 64'(1));
        chk("x0_stall", 64'(issue_stall), 64'(0));
        cycle();
        idle();
        #1 chk("x0_err", 64'(wb_err), 64'(0));
        cycle();

        // Reset with buffer full and registers busy
        issue_one(5'd4);
        issue_one(5'd8);
        issue_one(5'd10);
        issue_one(5'd11);
        idle();
        alu_valid = 1; alu_rd = 5'd10; alu_data = 32'h10;
        ld_valid = 1; ld_rd = 5'd11; ld_data = 32'h11;
        cycle();
        idle(); rst_n = 0;
        #1 chk("rst_mid_write", 64'(rf_write), 64'(0));
        chk("rst_mid_stall", 64'(issue_stall), 64'(1));
        chk("rst_mid_ready", 64'(ld_ready), 64'(0));
        cycle();
        rst_n = 1; use_rs1 = 1; rs1 = 5'd4; issue_rd = 5'd8;
        #1 chk("rst_after_stall", 64'(issue_stall), 64'(0));
        chk("rst_after_write", 64'(rf_write), 64'(0));
        cycle();

        // Randomized legal traffic
        do_reset();
        ld_active = 0;
        for (int n = 0; n < 3000; n++) begin
            alu_valid = 0;
            if (!ld_active && ($urandom % 3 == 0)) begin
                if (pool.size() != 0) begin
                    idx = $urandom_range(0, pool.size() - 1);
                    ld_rd = pool[idx]; pool.delete(idx);
                    ld_active = 1;
                end else if ($urandom % 4 == 0) begin
                    ld_rd = 0; ld_active = 1;
                end
                ld_data = $urandom;
            end
            ld_valid = ld_active;
            alu_data = $urandom;
            if (pool.size() != 0 && ($urandom % 2 == 0)) begin
                idx = $urandom_range(0, pool.size() - 1);
                alu_rd = pool[idx]; pool.delete(idx);
                alu_valid = 1;
            end else if ($urandom % 8 == 0) begin
                alu_rd = 0; alu_valid = 1;
            end
            issue_valid = ($urandom % 4 != 0);
            use_rs1 = $urandom; use_rs2 = $urandom;
            rs1 = 5'($urandom); rs2 = 5'($urandom); issue_rd = 5'($urandom);
            rst_n = ($urandom % 250 != 0);
            cycle();
            if (!rst_n) begin
                pool.delete(); ld_active = 0; rst_n = 1;
            end else begin
                if (g_iss_acc && issue_rd != 0) pool.push_back(issue_rd);
                if (g_ld_acc) ld_active = 0;
            end
        end

        // Writeback to a register that was never issued
        do_reset();
        alu_valid = 1; alu_rd = 5'd12; alu_data = 32'h5;
        #1 chk("err_write", 64'(rf_write), 64'(1));
        cycle();
        idle();
        for (int k = 0; k < 3; k++) begin
            #1 chk("err_sticky", 64'(wb_err), 64'(1));
            cycle();
        end
        rst_n = 0;
        cycle();
        rst_n = 1;
        #1 chk("err_cleared", 64'(wb_err), 64'(0));
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
